// File: rtl/spike_packet_encoder.sv
// Snapshots neuron spike flags at each timestep boundary and serialises the set bits,
// lowest index first, into source-address packets queued in a small valid/ready FIFO.
module spike_packet_encoder #(
    parameter int NUM_NEURONS  = 10,
    parameter int ADDR_WIDTH   = 12,
    parameter int BASE_ADDRESS = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   clear,
    input  logic [NUM_NEURONS-1:0] spike,
    output logic [ADDR_WIDTH-1:0]  packet_address,
    output logic                   packet_valid,
    input  logic                   packet_ready,
    output logic                   busy,
    output logic                   overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t                 r_state;
    logic [NUM_NEURONS-1:0] r_snapshot;
    logic                   r_clear_d;
    logic                   r_overflow;
    logic [ADDR_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_boundary;
    logic [NUM_NEURONS-1:0] w_lowbit;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_full;
    logic                   w_nonempty;
    logic                   w_push;
    logic                   w_pop;
    logic [ADDR_WIDTH-1:0]  w_push_addr;

    assign w_boundary = clear & ~r_clear_d;
    // Two's-complement trick isolates the lowest pending spike bit.
    assign w_lowbit   = r_snapshot & (~r_snapshot + NUM_NEURONS'(1));
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_push     = (r_state == S_SCAN) && !w_boundary && (r_snapshot != '0) && !w_full;
    assign w_pop      = w_nonempty && packet_ready;
    assign w_push_addr = ADDR_WIDTH'(BASE_ADDRESS) + ADDR_WIDTH'(w_idx);

    always_comb begin
        w_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (r_snapshot[i]) w_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_snapshot <= '0;
            r_clear_d  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_clear_d <= clear;
            case (r_state)
                S_IDLE: begin
                    if (w_boundary) begin
                        r_snapshot <= spike;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A new boundary always wins; unsent bits of the old snapshot are lost.
                    if (w_boundary) begin
                        if (r_snapshot != '0) r_overflow <= 1'b1;
                        r_snapshot <= spike;
                    end else if (r_snapshot == '0) begin
                        r_state <= S_IDLE;
                    end else if (!w_full) begin
                        r_snapshot <= r_snapshot & ~w_lowbit;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; the count alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_addr;
    end

    assign packet_valid   = w_nonempty;
    assign packet_address = w_nonempty ? r_mem[r_rd_ptr] : '0;
    assign busy           = (r_state == S_SCAN) || w_nonempty;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Directed bench for spike_packet_encoder: default instance plus a BASE_ADDRESS=4094
// instance sharing the same stimulus, checked against hand-computed packet sequences.
module tb_spike_packet_encoder;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        clear;
    logic [9:0]  spike;
    logic        packet_ready;
    logic [11:0] packet_address, packet_address_b;
    logic        packet_valid, packet_valid_b;
    logic        busy, busy_b;
    logic        overflow, overflow_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] q_a[$];
    logic [11:0] q_b[$];

    always #5 CLK = ~CLK;

    spike_packet_encoder dut (
        .CLK(CLK), .RESET(RESET), .clear(clear), .spike(spike),
        .packet_address(packet_address), .packet_valid(packet_valid),
        .packet_ready(packet_ready), .busy(busy), .overflow(overflow)
    );

    spike_packet_encoder #(.BASE_ADDRESS(4094)) dut_b (
        .CLK(CLK), .RESET(RESET), .clear(clear), .spike(spike),
        .packet_address(packet_address_b), .packet_valid(packet_valid_b),
        .packet_ready(packet_ready), .busy(busy_b), .overflow(overflow_b)
    );

    always @(posedge CLK) begin
        if (!RESET) begin
            if (packet_valid && packet_ready)     q_a.push_back(packet_address);
            if (packet_valid_b && packet_ready)   q_b.push_back(packet_address_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((busy || busy_b) && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, 32'(busy | busy_b), 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1; clear = 1'b0; spike = '0;
        step();
        RESET = 1'b0;
        step();
    endtask

    initial begin
        RESET = 1'b1; clear = 1'b0; spike = '1; packet_ready = 1'b0;

        // Scenario 1: reset with hostile inputs
        for (int c = 0; c < 2; c++) begin
            clear = ~clear;
            step();
            chk("rst_valid", 32'(packet_valid), 0);
            chk("rst_addr",  32'(packet_address), 0);
            chk("rst_busy",  32'(busy), 0);
            chk("rst_ovf",   32'(overflow), 0);
        end
        RESET = 1'b0; clear = 1'b0; spike = '0;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Scenario 2: bits 1,4,6 with clear held two cycles
        spike = 10'b0001010010; clear = 1'b1; packet_ready = 1'b1;
        step();                                   // E
        chk("s2_busy_E", 32'(busy), 1);
        chk("s2_valid_E", 32'(packet_valid), 0);
        step();                                   // E+1 (clear still high)
        clear = 1'b0; spike = '0;
        chk("s2_valid_E1", 32'(packet_valid), 1);
        chk("s2_pkt0", 32'(packet_address), 1);
        step();
        chk("s2_pkt1", 32'(packet_address), 4);
        step();
        chk("s2_pkt2", 32'(packet_address), 6);
        chk("s2_busy_E3", 32'(busy), 1);
        step();
        chk("s2_valid_end", 32'(packet_valid), 0);
        chk("s2_busy_end", 32'(busy), 0);
        chk("s2_ovf", 32'(overflow), 0);
        step();
        chk("s2_no_second", 32'(packet_valid), 0);

        // Scenario 3: all spikes with backpressure
        do_reset();
        q_a.delete(); q_b.delete();
        packet_ready = 1'b0; spike = '1; clear = 1'b1;
        step();
        clear = 1'b0; spike = '0;
        for (int c = 0; c < 10; c++) step();
        chk("s3_head", 32'(packet_address), 0);
        chk("s3_stall_busy", 32'(busy), 1);
        packet_ready = 1'b1;
        drain("s3_drain", 60);
        chk("s3_len", 32'(q_a.size()), 10);
        for (int i = 0; i < q_a.size() && i < 10; i++) chk($sformatf("s3_pkt%0d", i), 32'(q_a[i]), 32'(i));
        chk("s3_ovf", 32'(overflow), 0);

        // Scenario 4: second boundary while bits 4..9 still pending
        do_reset();
        q_a.delete(); q_b.delete();
        packet_ready = 1'b0; spike = '1; clear = 1'b1;
        step();                                   // E
        clear = 1'b0; spike = '0;
        for (int c = 0; c < 7; c++) step();       // up to E+7
        chk("s4_ovf_before", 32'(overflow), 0);
        spike = 10'b1000000000; clear = 1'b1;
        step();                                   // E+8
        clear = 1'b0; spike = '0;
        chk("s4_ovf_set", 32'(overflow), 1);
        step(); step();
        packet_ready = 1'b1;
        drain("s4_drain", 60);
        chk("s4_len", 32'(q_a.size()), 5);
        if (q_a.size() == 5) begin
            chk("s4_p0", 32'(q_a[0]), 0);
            chk("s4_p1", 32'(q_a[1]), 1);
            chk("s4_p2", 32'(q_a[2]), 2);
            chk("s4_p3", 32'(q_a[3]), 3);
            chk("s4_p4", 32'(q_a[4]), 9);
        end
        chk("s4_ovf_sticky", 32'(overflow), 1);

        // Scenario 5: address wrap on the BASE_ADDRESS=4094 instance
        do_reset();
        chk("s5_ovf_cleared", 32'(overflow), 0);
        q_a.delete(); q_b.delete();
        packet_ready = 1'b1; spike = 10'b0000000111; clear = 1'b1;
        step();
        clear = 1'b0; spike = '0;
        drain("s5_drain", 20);
        chk("s5_len", 32'(q_b.size()), 3);
        if (q_b.size() == 3) begin
            chk("s5_p0", 32'(q_b[0]), 4094);
            chk("s5_p1", 32'(q_b[1]), 4095);
            chk("s5_p2", 32'(q_b[2]), 0);
        end

        // Scenario 6: reset mid-scan with 3 queued and 5 pending
        do_reset();
        q_a.delete(); q_b.delete();
        packet_ready = 1'b0; spike = 10'b0011111111; clear = 1'b1;
        step();                                   // E
        clear = 1'b0; spike = '0;
        step(); step(); step();                   // pushes 0,1,2
        chk("s6_queued_head", 32'(packet_address), 0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("s6_valid_rst", 32'(packet_valid), 0);
        chk("s6_busy_rst", 32'(busy), 0);
        chk("s6_addr_rst", 32'(packet_address), 0);
        step();
        chk("s6_valid_after", 32'(packet_valid), 0);
        packet_ready = 1'b1; spike = 10'b0010000000; clear = 1'b1;
        step();
        clear = 1'b0; spike = '0;
        step();
        chk("s6_pkt7", 32'(packet_address), 7);
        drain("s6_drain", 20);
        chk("s6_len", 32'(q_a.size()), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
